// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and constants for the two-requester APB master arbiter.
//   state_t            - transfer FSM states (IDLE / SETUP / ACCESS)
//   req_idx_t          - 1-bit requester index
//   TIMEOUT_CYCLES_DEF - default ACCESS wait limit (used with APB_ARB_TIMEOUT_EN)
//   idx2onehot()       - requester index to one-hot 2-bit vector
// -----------------------------------------------------------------------------
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef logic req_idx_t;

    localparam int TIMEOUT_CYCLES_DEF = 255;

    function automatic logic [1:0] idx2onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_arb_rr.sv
// -----------------------------------------------------------------------------
// apb_arb_rr
// Two-way round-robin picker. The requester named by ptr has priority; the
// other one wins only when the priority requester is idle.
//   req   [1:0] in  - pending requests
//   ptr         in  - index of the requester currently holding priority
//   grant [1:0] out - one-hot winner, 0 when nothing is requested
// -----------------------------------------------------------------------------
module apb_arb_rr
    import apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[ptr])
            grant = idx2onehot(ptr);
        else if (req[~ptr])
            grant = idx2onehot(~ptr);
    end

endmodule

// File: rtl/apb_master_arb.sv
// -----------------------------------------------------------------------------
// apb_master_arb
// APB master shared by two requesters. A request is granted in IDLE
// (combinational gnt_o), its fields are captured into the APB registers, and
// the transfer runs SETUP -> ACCESS. Completion returns a one-cycle rvalid_o
// pulse to the owner together with rdata_o / err_o, which then hold until the
// next completion.
//
// Ports
//   clk_i, rst_i                    clock, async active-high reset
//   req_i/addr_i/we_i/wdata_i       per-requester request fields
//   gnt_o                           one-hot grant (request accepted this cycle)
//   rvalid_o/rdata_o/err_o          completion pulse and response
//   paddr_o/pwdata_o/pwrite_o       APB request fields (registered)
//   psel_o/penable_o                APB control (registered)
//   prdata_i/pready_i/pslverr_i     APB response
//
// Build option
//   APB_ARB_TIMEOUT_EN - when defined, an ACCESS phase that sees pready_i low
//   for TIMEOUT_CYCLES cycles is aborted with err_o=1 and rdata_o=0.
// -----------------------------------------------------------------------------
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [1:0]                     req_i,
    output logic [1:0]                     gnt_o,
    input  logic [1:0][APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]                     we_i,
    input  logic [1:0][APB_DATA_WIDTH-1:0] wdata_i,
    output logic [1:0]                     rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]      rdata_o,
    output logic                           err_o,
    output logic [APB_ADDR_WIDTH-1:0]      paddr_o,
    output logic [APB_DATA_WIDTH-1:0]      pwdata_o,
    output logic                           pwrite_o,
    output logic                           psel_o,
    output logic                           penable_o,
    input  logic [APB_DATA_WIDTH-1:0]      prdata_i,
    input  logic                           pready_i,
    input  logic                           pslverr_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state, state_nxt;
    req_idx_t   ptr, owner;
    logic [1:0] rr_grant;
    logic       take;     // a grant is being accepted this cycle
    logic       win;      // index of the granted requester
    logic       abort;
    logic       finish;   // transfer leaves ACCESS this cycle

    apb_arb_rr u_rr (
        .req   (req_i),
        .ptr   (ptr),
        .grant (rr_grant)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts ACCESS cycles with pready_i low; cleared whenever a transfer
    // is granted (i.e. on entry to SETUP).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            wait_cnt <= '0;
        else if (take)
            wait_cnt <= '0;
        else if (state == ACCESS && !pready_i)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Abort in the cycle that would be the TIMEOUT_CYCLES-th wait cycle.
    assign abort = (state == ACCESS) && !pready_i &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    assign take   = |gnt_o;
    assign win    = gnt_o[1];
    assign finish = (state == ACCESS) && (pready_i || abort);

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_i) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. Grant is only offered in IDLE, and is held off while
    // reset is asserted even though the state already reads IDLE.
    always_comb begin
        gnt_o = 2'b00;
        if (state == IDLE && !rst_i)
            gnt_o = rr_grant;
    end

    // Request capture, APB control and completion response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr       <= 1'b0;
            owner     <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pwrite_o  <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= 2'b00;
            rdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            rvalid_o <= 2'b00;
            if (take) begin
                ptr      <= ~win;   // priority passes to the other requester
                owner    <= win;
                paddr_o  <= addr_i[win];
                pwdata_o <= wdata_i[win];
                pwrite_o <= we_i[win];
                psel_o   <= 1'b1;
            end
            if (state == SETUP)
                penable_o <= 1'b1;
            if (finish) begin
                psel_o    <= 1'b0;
                penable_o <= 1'b0;
                rvalid_o  <= idx2onehot(owner);
                rdata_o   <= (abort || pwrite_o) ? '0 : prdata_i;
                err_o     <= abort | pslverr_i;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
module tb_apb_master_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req, gnt, we, rvalid;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][DW-1:0]  wdata;
    logic [DW-1:0]       rdata, pwdata, prdata;
    logic [AW-1:0]       paddr;
    logic                err, pwrite, psel, penable, pready, pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_master_arb #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .gnt_o     (gnt),
        .addr_i    (addr),
        .we_i      (we),
        .wdata_i   (wdata),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .err_o     (err),
        .paddr_o   (paddr),
        .pwdata_o  (pwdata),
        .pwrite_o  (pwrite),
        .psel_o    (psel),
        .penable_o (penable),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .pslverr_i (pslverr)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req = 2'b11; we = 2'b11; addr = '1; wdata = '1;
        pready = 1'b1; pslverr = 1'b1; prdata = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({gnt, rvalid, psel, penable, pwrite, err} !== 8'h00) begin
                errors++;
                $display("FAIL reset_ctrl: got %b required 00000000",
                         {gnt, rvalid, psel, penable, pwrite, err});
            end
            checks++;
            if (paddr !== '0 || pwdata !== '0 || rdata !== '0) begin
                errors++;
                $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h required all 0",
                         paddr, pwdata, rdata);
            end
            @(negedge clk);
        end
        rst = 1'b0; req = '0; pready = 1'b0; pslverr = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        req = 2'b01; addr[0] = 32'h1A10_0000; we[0] = 1'b0;
        pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL read_gnt: got %b required 01", gnt);
        end
        @(negedge clk); req = '0;
        checks++;
        if ({psel, penable, pwrite} !== 3'b100 || paddr !== 32'h1A10_0000) begin
            errors++;
            $display("FAIL read_setup: got sel/en/wr=%b paddr=%h required 100 1a100000",
                     {psel, penable, pwrite}, paddr);
        end
        @(negedge clk);
        checks++;
        if ({psel, penable} !== 2'b11 || rvalid !== 2'b00) begin
            errors++;
            $display("FAIL read_access: got sel/en=%b rvalid=%b required 11 00",
                     {psel, penable}, rvalid);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 2'b01 || rdata !== 32'hDEAD_BEEF || err !== 1'b0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL read_done: got rvalid=%b rdata=%h err=%b psel=%b required 01 deadbeef 0 0",
                     rvalid, rdata, err, psel);
        end
        pready = 1'b0; prdata = '0;
        @(negedge clk);
        checks++;
        if (rvalid !== 2'b00 || rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_hold: got rvalid=%b rdata=%h required 00 deadbeef", rvalid, rdata);
        end
    endtask

    task automatic test_wait_error();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int acc;
        bit seen;
        do_reset();
        @(negedge clk);
        req = 2'b10; we[1] = 1'b1; addr[1] = $urandom; wdata[1] = $urandom;
        a = addr[1]; d = wdata[1]; pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        #1;
        checks++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL werr_gnt: got %b required 10", gnt);
        end
        acc = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            req = '0; addr[1] = $urandom; wdata[1] = $urandom;
            if (rvalid !== 2'b00) begin
                seen = 1;
                checks++;
                if (rvalid !== 2'b10 || err !== 1'b1 || rdata !== '0) begin
                    errors++;
                    $display("FAIL werr_done: got rvalid=%b err=%b rdata=%h required 10 1 0",
                             rvalid, err, rdata);
                end
            end else if (penable) begin
                acc++;
                checks++;
                if (paddr !== a || pwdata !== d || pwrite !== 1'b1 || psel !== 1'b1) begin
                    errors++;
                    $display("FAIL werr_stable: got paddr=%h pwdata=%h wr=%b sel=%b required %h %h 1 1",
                             paddr, pwdata, pwrite, psel, a, d);
                end
                pready  = (acc == 5);
                pslverr = (acc == 5);
            end
        end
        checks++;
        if (!seen || acc != 5) begin
            errors++;
            $display("FAIL werr_len: got penable cycles=%0d done=%0d required 5 1", acc, seen);
        end
        pready = 1'b0; pslverr = 1'b0;
    endtask

    task automatic test_reset_in_access();
        int bad;
        do_reset();
        @(negedge clk);
        req = 2'b01; we[0] = 1'b0; addr[0] = $urandom; pready = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL rsta_gnt: got %b required 01", gnt);
        end
        @(negedge clk); req = '0;
        @(negedge clk);
        checks++;
        if ({psel, penable} !== 2'b11) begin
            errors++; $display("FAIL rsta_access: got sel/en=%b required 11", {psel, penable});
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({psel, penable} !== 2'b00) begin
            errors++; $display("FAIL rsta_drop: got sel/en=%b required 00", {psel, penable});
        end
        @(negedge clk);
        rst = 1'b0; pready = 1'b1; prdata = $urandom;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rsta_no_rvalid: got %0d rvalid cycles required 0", bad);
        end
        @(negedge clk);
        req = 2'b11; we = 2'b00;
        #1;
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL rsta_next_gnt: got %b required 01", gnt);
        end
        @(negedge clk);
        req = '0; pready = 1'b0;
    endtask

    // Transaction-level model: a granted transfer occupies the bus for
    // 3+w cycles (grant, SETUP, w waits + final ACCESS, then completion);
    // the next grant may share the completion cycle.
    task automatic test_traffic(input int ncyc, input int req_pct, input int max_wait);
        bit            busy;
        int            t, w, owner, ptr, winner, clr;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wdata, e_rdata, last_rdata;
        logic          e_err, last_err;
        logic [1:0]    exp_gnt, exp_rv;
        do_reset();
        busy = 0; t = 0; w = 0; owner = 0; ptr = 0; clr = -1;
        e_addr = '0; e_we = 0; e_wdata = '0; e_rdata = '0; e_err = 0;
        last_rdata = '0; last_err = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (clr >= 0) req[clr] = 1'b0;
            clr = -1;
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && $urandom_range(99) < req_pct) begin
                    req[i] = 1'b1; addr[i] = $urandom;
                    we[i] = 1'($urandom_range(1)); wdata[i] = $urandom;
                end
            end
            pready  = busy && (t == 2 + w);
            prdata  = $urandom;
            pslverr = 1'($urandom_range(1));
            if (pready) begin
                e_rdata = e_we ? '0 : prdata;
                e_err   = pslverr;
            end
            #1;
            if (busy && t == 3 + w) begin
                exp_rv = (owner == 1) ? 2'b10 : 2'b01;
                checks++;
                if (rvalid !== exp_rv || rdata !== e_rdata || err !== e_err) begin
                    errors++;
                    $display("FAIL traffic_done c%0d: got rvalid=%b rdata=%h err=%b required %b %h %b",
                             c, rvalid, rdata, err, exp_rv, e_rdata, e_err);
                end
                last_rdata = e_rdata; last_err = e_err; busy = 0;
            end else begin
                checks++;
                if (rvalid !== 2'b00 || rdata !== last_rdata || err !== last_err) begin
                    errors++;
                    $display("FAIL traffic_hold c%0d: got rvalid=%b rdata=%h err=%b required 00 %h %b",
                             c, rvalid, rdata, err, last_rdata, last_err);
                end
            end
            checks++;
            if (psel !== (busy && t >= 1) || penable !== (busy && t >= 2)) begin
                errors++;
                $display("FAIL traffic_ctrl c%0d: got sel/en=%b%b required %b%b",
                         c, psel, penable, busy && t >= 1, busy && t >= 2);
            end
            if (busy && t >= 1) begin
                checks++;
                if (paddr !== e_addr || pwrite !== e_we || pwdata !== e_wdata) begin
                    errors++;
                    $display("FAIL traffic_fields c%0d: got %h %b %h required %h %b %h",
                             c, paddr, pwrite, pwdata, e_addr, e_we, e_wdata);
                end
            end
            exp_gnt = 2'b00;
            winner  = -1;
            if (!busy && req != 2'b00) begin
                winner  = req[ptr] ? ptr : 1 - ptr;
                exp_gnt = (winner == 1) ? 2'b10 : 2'b01;
            end
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("FAIL traffic_gnt c%0d: got %b required %b", c, gnt, exp_gnt);
            end
            if (winner >= 0) begin
                busy = 1; t = 0; w = $urandom_range(max_wait); owner = winner;
                e_addr = addr[winner]; e_we = we[winner]; e_wdata = wdata[winner];
                ptr = 1 - winner; clr = winner;
            end
            if (busy) t++;
        end
        @(negedge clk);
        req = '0; pready = 1'b0;
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int acc;
        bit seen;
        do_reset();
        @(negedge clk);
        req = 2'b01; we[0] = 1'b0; addr[0] = $urandom; pready = 1'b0; prdata = '1;
        #1;
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL to_gnt: got %b required 01", gnt);
        end
        acc = 0; seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            req = '0;
            if (rvalid !== 2'b00) begin
                seen = 1;
                checks++;
                if (rvalid !== 2'b01 || err !== 1'b1 || rdata !== '0 || {psel, penable} !== 2'b00) begin
                    errors++;
                    $display("FAIL to_done: got rvalid=%b err=%b rdata=%h sel/en=%b%b required 01 1 0 00",
                             rvalid, err, rdata, psel, penable);
                end
            end else if (penable) begin
                acc++;
            end
        end
        checks++;
        if (!seen || acc != TO) begin
            errors++;
            $display("FAIL to_len: got access cycles=%0d done=%0d required %0d 1", acc, seen, TO);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        test_reset();
        test_single_read();
        test_wait_error();
        test_reset_in_access();
        test_traffic(40, 100, 0);
        test_traffic(400, 40, 3);
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
